// File: rtl/gpio_pkg.sv
// Shared constants for the gpio input path.
// Default widths/depths plus a counter-width helper.
package gpio_pkg;

    localparam int GPIO_WIDTH           = 8;
    localparam int GPIO_SYNC_STAGES     = 2;
    localparam int GPIO_DEBOUNCE_CYCLES = 16;

    // Debounce counter width, never below one bit.
    function automatic int cnt_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin synchroniser, debouncer and edge detector.
// Ports: clk, rst, pin (async), level, rise/fall pulses, rise_nxt/fall_nxt.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int S = GPIO_SYNC_STAGES,
    parameter int D = GPIO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);

    localparam int CW = cnt_width(D);

    logic [S-1:0]  sync_q;
    logic          sync;
    logic          stb_q;
    logic [CW-1:0] cnt_q;
    logic          rise_q;
    logic          fall_q;
    logic          accept;

    assign sync = sync_q[S-1];

    // Accept on the D-th consecutive mismatch cycle.
    always_comb begin
        accept   = (sync != stb_q) && (cnt_q == CW'(D - 1));
        rise_nxt = accept & sync;
        fall_nxt = accept & ~sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            stb_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[S-2:0], pin};
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
            if (sync == stb_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                stb_q <= sync;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = stb_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioning with sticky edge interrupts.
// Ports: pin_i, rise/fall enables, irq_clr_i in; level, edges, pending, irq out.
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] irq_clr_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] irq_pending_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] pend_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .S(SYNC_STAGES),
            .D(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .pin      (pin_i[i]),
            .level    (level_o[i]),
            .rise     (rise_o[i]),
            .fall     (fall_o[i]),
            .rise_nxt (rise_nxt[i]),
            .fall_nxt (fall_nxt[i])
        );
    end

    // Uses the pulse values being registered at this edge, so pending
    // rises together with the level/pulse outputs.
    assign set = (rise_nxt & rise_en_i) | (fall_nxt & fall_en_i);

    // Set wins over clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= set | (pend_q & ~irq_clr_i);
        end
    end

    assign irq_pending_o = pend_q;
    assign irq_o         = |pend_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Scoreboard bench for gpio_in_cond (WIDTH=8, S=2, D=4).
// Stimulus queues expected outputs per edge; a monitor checks them.
module tb_gpio_in_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pin_i;
    logic [7:0] rise_en_i;
    logic [7:0] fall_en_i;
    logic [7:0] irq_clr_i;
    logic [7:0] level_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic [7:0] irq_pending_o;
    logic       irq_o;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] lv;
        logic [7:0] rs;
        logic [7:0] fl;
        logic [7:0] pd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    gpio_in_cond #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pin_i         (pin_i),
        .rise_en_i     (rise_en_i),
        .fall_en_i     (fall_en_i),
        .irq_clr_i     (irq_clr_i),
        .level_o       (level_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .irq_pending_o (irq_pending_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: after each edge, check every expectation due now.
    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_run++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for edge %0d missed (now %0d)",
                         e.nm, e.cyc, cyc);
            end else if (level_o !== e.lv || rise_o !== e.rs ||
                         fall_o !== e.fl || irq_pending_o !== e.pd ||
                         irq_o !== (|e.pd)) begin
                n_fail++;
                $display("FAIL %s @%0d: got lv=%h rs=%h fl=%h pd=%h irq=%b, want lv=%h rs=%h fl=%h pd=%h irq=%b",
                         e.nm, cyc, level_o, rise_o, fall_o, irq_pending_o,
                         irq_o, e.lv, e.rs, e.fl, e.pd, |e.pd);
            end
        end
    end

    task automatic exp(input string nm, input int dc, input logic [7:0] lv,
                       input logic [7:0] rs, input logic [7:0] fl,
                       input logic [7:0] pd);
        exp_t e;
        e.cyc = cyc + dc;
        e.nm  = nm;
        e.lv  = lv;
        e.rs  = rs;
        e.fl  = fl;
        e.pd  = pd;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        pin_i     = 8'hFF;
        rise_en_i = 8'h00;
        fall_en_i = 8'h00;
        irq_clr_i = 8'h00;

        // Reset held three edges with all pins high.
        tick(1);
        exp("rst_hold1", 1, 8'h00, 8'h00, 8'h00, 8'h00);
        exp("rst_hold2", 2, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(2);
        rst = 1'b0;
        exp("rel_pre", 5, 8'h00, 8'h00, 8'h00, 8'h00);
        exp("rel_rise", 6, 8'hFF, 8'hFF, 8'h00, 8'h00);
        exp("rel_after", 7, 8'hFF, 8'h00, 8'h00, 8'h00);
        tick(7);

        // Bring every pin low.
        pin_i = 8'h00;
        exp("all_fall_pre", 5, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp("all_fall", 6, 8'h00, 8'h00, 8'hFF, 8'h00);
        exp("all_fall_after", 7, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(7);

        // Three-cycle glitch on pin 0 is rejected.
        pin_i = 8'h01;
        for (int k = 1; k <= 8; k++)
            exp("glitch", k, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(3);
        pin_i = 8'h00;
        tick(5);

        // Six-cycle pulse on pin 0 is accepted after 5 edges.
        pin_i = 8'h01;
        exp("long_pre", 5, 8'h00, 8'h00, 8'h00, 8'h00);
        exp("long_rise", 6, 8'h01, 8'h01, 8'h00, 8'h00);
        for (int k = 7; k <= 11; k++)
            exp("long_hold", k, 8'h01, 8'h00, 8'h00, 8'h00);
        exp("long_fall", 12, 8'h00, 8'h00, 8'h01, 8'h00);
        tick(6);
        pin_i = 8'h00;
        tick(7);

        // Raise pin 1 with interrupts disabled.
        pin_i = 8'h02;
        exp("p1_up", 6, 8'h02, 8'h02, 8'h00, 8'h00);
        tick(7);

        // Pin 0 up (rise enabled), pin 1 down (fall enabled).
        rise_en_i = 8'h01;
        fall_en_i = 8'h02;
        pin_i     = 8'h01;
        exp("irq_pre", 5, 8'h02, 8'h00, 8'h00, 8'h00);
        exp("irq_set", 6, 8'h01, 8'h01, 8'h02, 8'h03);
        exp("irq_hold", 7, 8'h01, 8'h00, 8'h00, 8'h03);
        tick(7);

        // Pin 0 down: fall not enabled on pin 0.
        pin_i = 8'h00;
        exp("p0_fall_noirq", 6, 8'h00, 8'h00, 8'h01, 8'h03);
        exp("p0_fall_after", 7, 8'h00, 8'h00, 8'h00, 8'h03);
        tick(7);

        // Dropping enables keeps pending bits.
        rise_en_i = 8'h00;
        fall_en_i = 8'h00;
        exp("en_off_keep", 1, 8'h00, 8'h00, 8'h00, 8'h03);
        tick(1);

        // Write-1-to-clear, one bit at a time.
        irq_clr_i = 8'h01;
        exp("clr0", 1, 8'h00, 8'h00, 8'h00, 8'h02);
        tick(1);
        irq_clr_i = 8'h02;
        exp("clr1", 1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(1);
        irq_clr_i = 8'h00;
        exp("clr_idle", 1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(1);

        // Clear held on pin 2 across its enabled rise: set wins.
        rise_en_i = 8'h04;
        irq_clr_i = 8'h04;
        pin_i     = 8'h04;
        exp("coll_pre", 5, 8'h00, 8'h00, 8'h00, 8'h00);
        exp("coll_set", 6, 8'h04, 8'h04, 8'h00, 8'h04);
        tick(6);
        irq_clr_i = 8'h00;
        exp("coll_keep", 1, 8'h04, 8'h00, 8'h00, 8'h04);
        tick(2);

        // Reset while pin 3 is mid-debounce (cnt=2).
        pin_i = 8'h0C;
        for (int k = 1; k <= 4; k++)
            exp("mid_cnt", k, 8'h04, 8'h00, 8'h00, 8'h04);
        tick(4);
        rst = 1'b1;
        exp("mid_rst", 1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++)
            exp("post_rst_wait", k, 8'h00, 8'h00, 8'h00, 8'h00);
        exp("post_rst_rise", 6, 8'h0C, 8'h0C, 8'h00, 8'h04);
        exp("post_rst_after", 7, 8'h0C, 8'h00, 8'h00, 8'h04);
        tick(8);

        // Drain the scoreboard, bounded.
        for (int k = 0; k < 20 && q.size() > 0; k++) tick(1);
        if (q.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

Input-conditioning stage feeding the `gpio` block's input path. Each asynchronous pin is synchronised, debounced with a per-pin counter and edge-detected. Rising and falling edges can raise a sticky per-pin interrupt, which software clears with a write-1-to-clear pulse. `gpio` consumes the debounced levels, the edge pulses and the pending/IRQ outputs.

## Interface
- `WIDTH`, 8: number of pins; must be ≥1.
- `SYNC_STAGES`, 2: synchroniser depth `S`; must be ≥2.
- `DEBOUNCE_CYCLES`, 16: debounce depth `D`, i.e. consecutive synced-mismatch cycles before the level is accepted; must be ≥1.
- `clk` input 1: sole clock; every flop is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `pin_i` input WIDTH: raw asynchronous pad inputs.
- `rise_en_i` input WIDTH: per-pin rising-edge interrupt enable.
- `fall_en_i` input WIDTH: per-pin falling-edge interrupt enable.
- `irq_clr_i` input WIDTH: write-1-to-clear pulse for pending bits.
- `level_o` output WIDTH: debounced pin level.
- `rise_o` output WIDTH: one-cycle pulse on an accepted 0→1 transition.
- `fall_o` output WIDTH: one-cycle pulse on an accepted 1→0 transition.
- `irq_pending_o` output WIDTH: sticky per-pin interrupt flags.
- `irq_o` output 1: OR-reduction of `irq_pending_o`.

## Operation
Pins are fully independent; the following applies per pin `i`.
- **Synchroniser:** a chain of `S` flops. `sync` is the last flop.
- **Debounce state:** stable value `stb` and counter `cnt`.
  - Counter width is `CW = $clog2(D)`, minimum 1.
- **Debounce rule, evaluated each cycle:**
  - If `sync == stb`: `cnt <= 0`.
  - Else if `cnt == D-1`: `stb <= sync`, `cnt <= 0`, and the edge pulse is registered.
  - Else: `cnt <= cnt + 1`.
- **Glitch rejection:** a mismatch lasting fewer than `D` consecutive cycles resets `cnt` and changes nothing. The counter never wraps.
- **Edge outputs:**
  - `rise_o[i]` is registered high for exactly one cycle, in the same cycle `level_o[i]` first shows 1.
  - `fall_o[i]` is the same for the transition to 0.
- **Pending bits:**
  - `set = (rise_o & rise_en_i) | (fall_o & fall_en_i)`, where `rise_o`/`fall_o` are the values registered at the same edge.
  - Next value: `pend <= set | (pend & ~irq_clr_i)`.
  - Set wins over a simultaneous clear, so no event is lost.
  - Enables gate only the setting of a bit. Deasserting an enable does not clear an existing pending bit.
- **IRQ output:** `irq_o` is combinational `|irq_pending_o`, driven from flops only.
- **Reset values:** all flops clear at the first rising edge with `rst=1`, giving the following outputs:
  - `level_o = 0`
  - `rise_o = 0`, `fall_o = 0`
  - `irq_pending_o = 0`
  - `irq_o = 0`
- **Reset mid-operation:** in-progress debounce counts and pending flags are discarded.
- **Pin high at reset release:** treated as a normal 0→1 transition. `rise_o` pulses after the latency given in Timing.

## Timing
- **Input latency:** let `pin_i[i]` change before edge 0 and stay stable.
  - `level_o[i]` and the edge pulse change after edge `S+D-1`.
  - `irq_pending_o[i]` and `irq_o` change at that same edge.
  - Total latency is `S+D` edges when counting edge 0.
- **Clear latency:** asserting `irq_clr_i[i]` in cycle k clears the bit after edge k; `irq_o` falls in the same cycle if no other bit is pending.
- **Minimum spacing:** two accepted transitions on one pin are at least `D` cycles apart, so edge pulses on one pin never abut.
- **No handshake:** `pin_i` is sampled every cycle. Clear pulses may be held for multiple cycles, and holding one keeps the bit clear except in a cycle where `set` is asserted.

## Structure
- **Package `gpio_pkg`:** holds the default constants `GPIO_WIDTH=8`, `GPIO_SYNC_STAGES=2` and `GPIO_DEBOUNCE_CYCLES=16`, shared with `gpio`.
- **Sub-module `gpio_debounce`:** single-bit, parameterised on `S` and `D`. Contains the synchroniser, counter, `stb` and the rise/fall pulse registers.
- **Top level:** `gpio_in_cond` instantiates `gpio_debounce` `WIDTH` times in a generate loop and holds the pending register plus the `irq_o` reduction.

## Test plan
Bench configuration: `WIDTH=8`, `S=2`, `D=4`.
1. **Reset:** hold `rst` high for 3 cycles with `pin_i=8'hFF` → all outputs 0 during reset. After release, `level_o=8'hFF` and `rise_o=8'hFF` appear after edge 5 following release; `rise_o` is high for 1 cycle.
2. **Glitch rejection:** with `level_o[0]=0`, raise `pin_i[0]` for 3 cycles → `level_o[0]` stays 0 and no pulses occur. Hold it for 6 cycles → `rise_o[0]` pulses once, exactly 5 edges after the pin edge.
3. **Edge interrupts:** `rise_en_i=8'h01`, `fall_en_i=8'h02`; toggle pin 0 up and pin 1 down → `irq_pending_o=8'h03` and `irq_o=1`. Toggle pin 0 down → pending unchanged, because `fall_en_i[0]=0`.
4. **Clear:** from pending `8'h03`, pulse `irq_clr_i=8'h01` → next cycle pending is `8'h02` and `irq_o=1`. Pulse `8'h02` → pending `8'h00` and `irq_o=0`.
5. **Set/clear collision:** hold `irq_clr_i[2]=1` across the cycle in which `rise_o[2]` and `rise_en_i[2]` are both 1 → `irq_pending_o[2]=1` afterwards.
6. **Reset mid-debounce:** assert `rst` for 1 cycle while pin 3 has `cnt=2` → no pulse. The pin then needs a full 5 further edges before acceptance.
